// File: rtl/aes_usb_pkg.sv
// Shared types and sizes for the USB-to-AES plaintext path.
package aes_usb_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        START    = 2'd1,
        WAIT_AES = 2'd2,
        PAD      = 2'd3
    } state_t;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_W     = 128;

endpackage

// File: rtl/pad_gen.sv
// PKCS#7-style pad value and last-pad-byte flag derived from the byte count.
// Only built when PLAINTEXT_PAD_EN is defined.
`ifdef PLAINTEXT_PAD_EN
module pad_gen #(
    parameter int NUM_BYTES = 16,
    parameter int BC_W      = 5
) (
    input  logic [BC_W-1:0] i_byte_cnt,
    output logic [7:0]      o_pad_value,
    output logic            o_last
);

    assign o_pad_value = 8'(NUM_BYTES) - 8'(i_byte_cnt);
    assign o_last      = (i_byte_cnt == BC_W'(NUM_BYTES - 1));

endmodule
`endif

// File: rtl/plaintext_packer.sv
// Packs bytes from the plaintext FIFO into a block and hands it to the AES core.
// Optional flush/padding support is enabled with the PLAINTEXT_PAD_EN macro.
module plaintext_packer
    import aes_usb_pkg::*;
#(
    parameter int NUM_BYTES = BLOCK_BYTES,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   fifo_empty,
    input  logic [7:0]             fifo_r_data,
    output logic                   fifo_r_enable,
    input  logic                   aes_busy,
    input  logic                   aes_complete,
    output logic                   aes_start,
    output logic [8*NUM_BYTES-1:0] block_data,
    output logic [CNT_W-1:0]       blk_count
`ifdef PLAINTEXT_PAD_EN
    ,
    input  logic                   flush
`endif
);

    localparam int BC_W = $clog2(NUM_BYTES) + 1;
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(NUM_BYTES - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [BC_W-1:0]          r_byte_cnt;
    logic [8*NUM_BYTES-1:0]   r_block;
    logic [CNT_W-1:0]         r_blk_count;
    logic                     w_pop;
    logic                     w_wr_en;
    logic [7:0]               w_wr_byte;

    assign w_pop         = (r_state == FILL) && !fifo_empty;
    assign fifo_r_enable = w_pop;
    assign block_data    = r_block;
    assign blk_count     = r_blk_count;

`ifdef PLAINTEXT_PAD_EN
    logic [7:0]      r_pad_val;
    logic [BC_W-1:0] w_pad_cnt;
    logic [7:0]      w_pad_value;
    logic            w_pad_last;

    // In FILL the pad value must account for a byte popped alongside flush.
    assign w_pad_cnt = (r_state == FILL) ? (r_byte_cnt + BC_W'(w_pop)) : r_byte_cnt;

    pad_gen #(
        .NUM_BYTES (NUM_BYTES),
        .BC_W      (BC_W)
    ) u_pad_gen (
        .i_byte_cnt  (w_pad_cnt),
        .o_pad_value (w_pad_value),
        .o_last      (w_pad_last)
    );

    assign w_wr_en   = w_pop || (r_state == PAD);
    assign w_wr_byte = (r_state == PAD) ? r_pad_val : fifo_r_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pad_val <= '0;
        end else if (r_state == FILL && w_state_next == PAD) begin
            r_pad_val <= w_pad_value;
        end
    end
`else
    assign w_wr_en   = w_pop;
    assign w_wr_byte = fifo_r_data;
`endif

    always_comb begin
        w_state_next = r_state;
        aes_start    = 1'b0;
        case (r_state)
            FILL: begin
                if (w_pop && r_byte_cnt == LAST_IDX) begin
                    w_state_next = START;
                end
`ifdef PLAINTEXT_PAD_EN
                else if (flush && r_byte_cnt != '0) begin
                    w_state_next = PAD;
                end
`endif
            end
            START: begin
                if (!aes_busy) begin
                    aes_start    = 1'b1;
                    w_state_next = WAIT_AES;
                end
            end
            WAIT_AES: begin
                if (aes_complete) begin
                    w_state_next = FILL;
                end
            end
            PAD: begin
`ifdef PLAINTEXT_PAD_EN
                if (w_pad_last) begin
                    w_state_next = START;
                end
`else
                w_state_next = FILL;
`endif
            end
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= FILL;
            r_byte_cnt  <= '0;
            r_block     <= '0;
            r_blk_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == WAIT_AES && aes_complete) begin
                r_byte_cnt <= '0;
            end else if (w_wr_en) begin
                r_byte_cnt <= r_byte_cnt + BC_W'(1);
            end
            if (aes_start) begin
                r_blk_count <= r_blk_count + CNT_W'(1);
            end
            // Old bytes are never cleared; each lane is simply overwritten in turn.
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (w_wr_en && r_byte_cnt == BC_W'(i)) begin
                    r_block[8*i +: 8] <= w_wr_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_plaintext_packer.sv
// Self-checking bench for plaintext_packer: reset table, scripted corner cases,
// and randomized traffic against a byte-stream reference model.
module tb_plaintext_packer;
    import aes_usb_pkg::*;

    localparam int NB = 16;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            fifo_empty;
    logic [7:0]      fifo_r_data;
    logic            fifo_r_enable;
    logic            aes_busy;
    logic            aes_complete;
    logic            aes_start;
    logic [8*NB-1:0] block_data;
    logic [CW-1:0]   blk_count;
    logic            flushIn;

    plaintext_packer #(.NUM_BYTES(NB), .CNT_W(CW)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .fifo_empty    (fifo_empty),
        .fifo_r_data   (fifo_r_data),
        .fifo_r_enable (fifo_r_enable),
        .aes_busy      (aes_busy),
        .aes_complete  (aes_complete),
        .aes_start     (aes_start),
        .block_data    (block_data),
        .blk_count     (blk_count)
`ifdef PLAINTEXT_PAD_EN
        ,
        .flush         (flushIn)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // FIFO contents and reference model of the packer's observable behaviour.
    logic [7:0]   fifoQ[$];
    int           mHeld;
    bit           mWaiting;
    int           mPadLeft;
    logic [7:0]   mPadVal;
    logic [127:0] mBlock;
    int           mBlk;
    bit           sampledPop;
    int           stepCount;
    bit           sawStart;
    int           startStep;
    logic [127:0] startBlock;

    typedef struct {
        logic empty;
        logic busy;
        logic complete;
        logic expEnable;
        logic expStart;
    } resetVec_t;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic driveFifo();
        fifo_empty  = (fifoQ.size() == 0);
        fifo_r_data = (fifoQ.size() == 0) ? 8'h00 : fifoQ[0];
    endtask

    task automatic pushBytes(input int n, input logic [7:0] base, input bit incr);
        for (int i = 0; i < n; i++) fifoQ.push_back(incr ? 8'(base + 8'(i)) : base);
        driveFifo();
    endtask

    task automatic modelCycle();
        bit empty;
        bit expPop;
        bit expStart;
        int heldBefore;
        empty    = (fifoQ.size() == 0);
        expPop   = !mWaiting && mHeld < NB && mPadLeft == 0 && !empty;
        expStart = !mWaiting && mHeld == NB && !aes_busy;
        checkOutput("fifo_r_enable", 128'(fifo_r_enable), 128'(expPop));
        checkOutput("aes_start", 128'(aes_start), 128'(expStart));
        checkOutput("blk_count", 128'(blk_count), 128'(CW'(mBlk)));
        if (mHeld == NB) checkOutput("block_data", block_data, mBlock);
        sampledPop = fifo_r_enable;
        if (aes_start) begin
            sawStart   = 1'b1;
            startStep  = stepCount;
            startBlock = block_data;
        end
        heldBefore = mHeld;
        if (expStart) begin
            mWaiting = 1'b1;
            mBlk++;
        end else if (mWaiting) begin
            if (aes_complete) begin
                mWaiting = 1'b0;
                mHeld    = 0;
            end
        end else if (mPadLeft > 0) begin
            mBlock[8*mHeld +: 8] = mPadVal;
            mHeld++;
            mPadLeft--;
        end else if (mHeld < NB) begin
            if (expPop) begin
                mBlock[8*mHeld +: 8] = fifoQ[0];
                mHeld++;
            end
            if (flushIn && heldBefore > 0 && mHeld < NB) begin
                mPadLeft = NB - mHeld;
                mPadVal  = 8'(NB - mHeld);
            end
        end
    endtask

    // One clock: check at the falling edge, then let the FIFO react after the rising edge.
    task automatic applyStimulus();
        @(negedge clk);
        stepCount++;
        modelCycle();
        @(posedge clk);
        #1;
        if (sampledPop) void'(fifoQ.pop_front());
        aes_complete = 1'b0;
        flushIn      = 1'b0;
        driveFifo();
    endtask

    task automatic runSteps(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic runUntilStart(input int limit, input string name);
        sawStart = 1'b0;
        for (int i = 0; i < limit && !sawStart; i++) applyStimulus();
        checkOutput(name, 128'(sawStart), 128'(1));
    endtask

    task automatic doReset();
        resetVec_t vecs[4];
        vecs[0] = '{empty: 1'b0, busy: 1'b0, complete: 1'b0, expEnable: 1'b1, expStart: 1'b0};
        vecs[1] = '{empty: 1'b1, busy: 1'b0, complete: 1'b0, expEnable: 1'b0, expStart: 1'b0};
        vecs[2] = '{empty: 1'b0, busy: 1'b1, complete: 1'b1, expEnable: 1'b1, expStart: 1'b0};
        vecs[3] = '{empty: 1'b1, busy: 1'b1, complete: 1'b1, expEnable: 1'b0, expStart: 1'b0};
        n_rst = 1'b0;
        fifoQ.delete();
        mHeld = 0; mWaiting = 0; mPadLeft = 0; mPadVal = '0; mBlock = '0; mBlk = 0;
        for (int i = 0; i < 4; i++) begin
            fifo_empty   = vecs[i].empty;
            fifo_r_data  = 8'h5A;
            aes_busy     = vecs[i].busy;
            aes_complete = vecs[i].complete;
            #1;
            checkOutput("rst_fifo_r_enable", 128'(fifo_r_enable), 128'(vecs[i].expEnable));
            checkOutput("rst_aes_start", 128'(aes_start), 128'(vecs[i].expStart));
            checkOutput("rst_block_data", block_data, 128'h0);
            checkOutput("rst_blk_count", 128'(blk_count), 128'h0);
        end
        aes_busy = 1'b0; aes_complete = 1'b0; flushIn = 1'b0;
        driveFifo();
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] expBlk;
        n_rst = 1'b0; aes_busy = 1'b0; aes_complete = 1'b0; flushIn = 1'b0;
        fifo_empty = 1'b1; fifo_r_data = 8'h00;
        stepCount = 0; sawStart = 1'b0; startStep = 0; startBlock = '0; sampledPop = 1'b0;
        doReset();

        // Minimum latency with bytes 0x00..0x0F.
        pushBytes(16, 8'h00, 1'b1);
        stepCount = 0;
        runUntilStart(40, "first_start_timeout");
        checkOutput("first_start_cycle", 128'(startStep), 128'(17));
        checkOutput("first_block", startBlock, 128'h0F0E0D0C0B0A09080706050403020100);
        checkOutput("first_blk_count", 128'(blk_count), 128'(1));
        runSteps(2);
        aes_complete = 1'b1;
        applyStimulus();

        // AES busy for 5 cycles after a full block, with a stray complete in START.
        aes_busy = 1'b1;
        pushBytes(16, 8'h10, 1'b1);
        sawStart = 1'b0;
        runSteps(17);
        aes_complete = 1'b1;
        runSteps(4);
        checkOutput("busy_no_start", 128'(sawStart), 128'(0));
        aes_busy  = 1'b0;
        stepCount = 0;
        runUntilStart(3, "busy_start_timeout");
        checkOutput("busy_release_cycle", 128'(startStep), 128'(1));
        aes_complete = 1'b1;
        applyStimulus();

        // FIFO runs dry after 7 bytes, stray complete while filling, refill later.
        pushBytes(7, 8'h30, 1'b1);
        runSteps(12);
        aes_complete = 1'b1;
        runSteps(15);
        pushBytes(9, 8'h37, 1'b1);
        runUntilStart(30, "refill_start_timeout");
        checkOutput("refill_block", startBlock, 128'h3F3E3D3C3B3A39383736353433323130);

        // Next block already queued: first pop must follow complete directly.
        pushBytes(16, 8'h40, 1'b1);
        runSteps(3);
        aes_complete = 1'b1;
        runSteps(10);

        // Reset mid-block, then a fresh stream.
        doReset();
        pushBytes(16, 8'h80, 1'b1);
        runUntilStart(40, "post_reset_start_timeout");
        checkOutput("post_reset_block", startBlock, 128'h8F8E8D8C8B8A89888786858483828180);
        checkOutput("post_reset_blk_count", 128'(blk_count), 128'(1));
        aes_complete = 1'b1;
        applyStimulus();

`ifdef PLAINTEXT_PAD_EN
        pushBytes(10, 8'hAA, 1'b0);
        runSteps(10);
        flushIn = 1'b1;
        runUntilStart(20, "pad_start_timeout");
        checkOutput("pad_block", startBlock, 128'h060606060606AAAAAAAAAAAAAAAAAAAA);
        aes_complete = 1'b1;
        applyStimulus();
        pushBytes(16, 8'hC0, 1'b1);
        runUntilStart(40, "after_pad_start_timeout");
        checkOutput("after_pad_block", startBlock, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);
        aes_complete = 1'b1;
        applyStimulus();
`endif

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && fifoQ.size() < 40) pushBytes(1, 8'($urandom), 1'b0);
            aes_busy = ($urandom_range(0, 3) == 0);
            if (mWaiting) aes_complete = ($urandom_range(0, 3) == 0);
            else          aes_complete = ($urandom_range(0, 15) == 0);
`ifdef PLAINTEXT_PAD_EN
            flushIn = ($urandom_range(0, 24) == 0);
`endif
            applyStimulus();
        end
        checkOutput("random_blocks_seen", 128'(mBlk > 20), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
